// File: rtl/issue_select_port.sv
// Age-ordered issue selector for one RS bank feeding NUM_FU issue slots.
// Grants are combinational; each slot is a one-deep valid/ready register toward its FU.
module issue_select_port #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_FU      = 3,
  parameter int PAYLOAD_W   = 128,
  parameter int AGE_W       = 8,
  parameter int BMASK_W     = 4,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_ENTRIES-1:0]         entry_ready,
  input  logic [NUM_ENTRIES*AGE_W-1:0]   entry_age,
  input  logic [NUM_ENTRIES*BMASK_W-1:0] entry_bmask,
  input  logic [NUM_ENTRIES*PAYLOAD_W-1:0] entry_payload,
  output logic [NUM_FU-1:0]              clear_valid,
  output logic [NUM_FU*IDX_W-1:0]        clear_idx,
  output logic [NUM_FU-1:0]              fu_valid,
  output logic [NUM_FU*PAYLOAD_W-1:0]    fu_payload,
  output logic [NUM_FU*BMASK_W-1:0]      fu_bmask,
  input  logic [NUM_FU-1:0]              fu_ready,
  input  logic                           squash_valid,
  input  logic [BMASK_W-1:0]             squash_bmask,
  input  logic                           resolve_valid,
  input  logic [BMASK_W-1:0]             resolve_bmask,
  output logic [31:0]                    issue_count
);

  logic [NUM_FU-1:0]    r_valid;
  logic [PAYLOAD_W-1:0] r_payload [NUM_FU];
  logic [BMASK_W-1:0]   r_bmask   [NUM_FU];
  logic [31:0]          r_count;

  logic [NUM_ENTRIES-1:0] w_cand;
  logic [NUM_FU-1:0]      w_free;
  logic [NUM_FU-1:0]      w_grant;
  logic [IDX_W-1:0]       w_gidx    [NUM_FU];
  logic [NUM_FU-1:0]      w_hs;
  logic [31:0]            w_hs_cnt;
  logic [NUM_FU-1:0]      w_valid_nx;
  logic [BMASK_W-1:0]     w_bmask_nx [NUM_FU];
  logic [PAYLOAD_W-1:0]   w_gpayload [NUM_FU];

  // Modular age compare: a is older than b when b is ahead of a by less than half the ring.
  function automatic logic is_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[AGE_W-1];
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [31:0] n);
    logic [32:0] s;
    s = {1'b0, c} + {1'b0, n};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign w_free = ~r_valid | fu_ready;
  assign w_hs   = r_valid & fu_ready;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_cand[i] = entry_ready[i] &&
                  !(squash_valid && |(entry_bmask[i*BMASK_W +: BMASK_W] & squash_bmask));
    end
  end

  // Slots are filled in index order; each picks the oldest remaining candidate.
  always_comb begin
    logic [NUM_ENTRIES-1:0] rem;
    logic                   found;
    logic [IDX_W-1:0]       best;
    logic [AGE_W-1:0]       best_age;
    rem     = w_cand;
    w_grant = '0;
    for (int s = 0; s < NUM_FU; s++) begin
      w_gidx[s] = '0;
      found     = 1'b0;
      best      = '0;
      best_age  = '0;
      if (w_free[s]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (rem[i] && (!found || is_older(entry_age[i*AGE_W +: AGE_W], best_age))) begin
            found    = 1'b1;
            best     = IDX_W'(i);
            best_age = entry_age[i*AGE_W +: AGE_W];
          end
        end
      end
      if (found) begin
        w_grant[s] = 1'b1;
        w_gidx[s]  = best;
        rem[best]  = 1'b0;
      end
    end
  end

  always_comb begin
    logic [BMASK_W-1:0] gbm;
    logic [BMASK_W-1:0] live_bm;
    logic               kill;
    w_hs_cnt = '0;
    for (int s = 0; s < NUM_FU; s++) begin
      w_hs_cnt      = w_hs_cnt + 32'(w_hs[s]);
      gbm           = entry_bmask[int'(w_gidx[s])*BMASK_W +: BMASK_W];
      w_gpayload[s] = entry_payload[int'(w_gidx[s])*PAYLOAD_W +: PAYLOAD_W];
      // Squash looks at the pre-resolve mask of both the held and the incoming entry.
      live_bm       = (r_valid[s] ? r_bmask[s] : '0) | (w_grant[s] ? gbm : '0);
      kill          = squash_valid && |(live_bm & squash_bmask);
      if (kill)             w_valid_nx[s] = 1'b0;
      else if (w_grant[s])  w_valid_nx[s] = 1'b1;
      else if (w_hs[s])     w_valid_nx[s] = 1'b0;
      else                  w_valid_nx[s] = r_valid[s];
      w_bmask_nx[s] = (w_grant[s] ? gbm : r_bmask[s]) &
                      ~(resolve_valid ? resolve_bmask : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nx;
      r_count <= sat_add(r_count, w_hs_cnt);
    end
    for (int s = 0; s < NUM_FU; s++) begin
      if (clear_valid[s]) r_payload[s] <= w_gpayload[s];
      r_bmask[s] <= w_bmask_nx[s];
    end
  end

  assign clear_valid = w_grant & {NUM_FU{reset}};
  assign fu_valid    = r_valid;
  assign issue_count = r_count;

  always_comb begin
    for (int s = 0; s < NUM_FU; s++) begin
      clear_idx[s*IDX_W +: IDX_W]         = w_gidx[s];
      fu_payload[s*PAYLOAD_W +: PAYLOAD_W] = r_payload[s];
      fu_bmask[s*BMASK_W +: BMASK_W]       = r_bmask[s];
    end
  end

endmodule

// File: tb/tb_issue_select_port.sv
// Directed bench for issue_select_port with default parameters (16 entries, 3 slots).
module tb_issue_select_port;
  localparam int NE = 16, NF = 3, PW = 128, AW = 8, BW = 4, IW = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NE-1:0]    entry_ready = '0;
  logic [NE*AW-1:0] entry_age = '0;
  logic [NE*BW-1:0] entry_bmask = '0;
  logic [NE*PW-1:0] entry_payload = '0;
  logic [NF-1:0]    clear_valid;
  logic [NF*IW-1:0] clear_idx;
  logic [NF-1:0]    fu_valid;
  logic [NF*PW-1:0] fu_payload;
  logic [NF*BW-1:0] fu_bmask;
  logic [NF-1:0]    fu_ready = '1;
  logic             squash_valid = 1'b0;
  logic [BW-1:0]    squash_bmask = '0;
  logic             resolve_valid = 1'b0;
  logic [BW-1:0]    resolve_bmask = '0;
  logic [31:0]      issue_count;

  int total = 0;
  int bad = 0;

  logic [15:0] st_rdy [4] = '{16'h03F8, 16'h03E0, 16'h0380, 16'h0200};
  logic [2:0]  st_cv  [4] = '{3'b101, 3'b101, 3'b101, 3'b001};
  logic [3:0]  st_s0  [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
  logic [3:0]  st_s2  [4] = '{4'd4, 4'd6, 4'd8, 4'd0};
  logic [31:0] st_cnt [4] = '{32'd0, 32'd2, 32'd4, 32'd6};

  issue_select_port dut (
    .clock(clock), .reset(reset),
    .entry_ready(entry_ready), .entry_age(entry_age), .entry_bmask(entry_bmask),
    .entry_payload(entry_payload),
    .clear_valid(clear_valid), .clear_idx(clear_idx),
    .fu_valid(fu_valid), .fu_payload(fu_payload), .fu_bmask(fu_bmask), .fu_ready(fu_ready),
    .squash_valid(squash_valid), .squash_bmask(squash_bmask),
    .resolve_valid(resolve_valid), .resolve_bmask(resolve_bmask),
    .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] pl(input int i);
    return PW'(32'hCAFE0000 + 32'(i));
  endfunction
  function automatic logic [IW-1:0] cidx(input int s);
    return clear_idx[s*IW +: IW];
  endfunction
  function automatic logic [PW-1:0] fpl(input int s);
    return fu_payload[s*PW +: PW];
  endfunction
  function automatic logic [BW-1:0] fbm(input int s);
    return fu_bmask[s*BW +: BW];
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    entry_age[i*AW +: AW]   = a;
    entry_bmask[i*BW +: BW] = b;
  endtask

  task automatic do_reset;
    reset = 1'b0; entry_ready = '0; fu_ready = '1;
    squash_valid = 1'b0; squash_bmask = '0; resolve_valid = 1'b0; resolve_bmask = '0;
    for (int i = 0; i < NE; i++) set_entry(i, AW'(i), '0);
    tick;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; entry_ready = '1; fu_ready = '1;
    for (int i = 0; i < NE; i++) set_entry(i, AW'(i), '0);
    tick; tick;
    total++; if (clear_valid !== 3'b000) begin bad++; $display("FAIL rst_cv got=%b exp=000", clear_valid); end
    total++; if (fu_valid !== 3'b000) begin bad++; $display("FAIL rst_fuv got=%b exp=000", fu_valid); end
    total++; if (issue_count !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", issue_count); end
    reset = 1'b1; #1;
    total++; if (clear_valid !== 3'b111) begin bad++; $display("FAIL rel_cv got=%b exp=111", clear_valid); end
    total++; if (clear_idx !== 12'h210) begin bad++; $display("FAIL rel_idx got=%h exp=210", clear_idx); end
    tick;
    entry_ready = '0; #1;
    total++; if (fu_valid !== 3'b111) begin bad++; $display("FAIL rel_fuv got=%b exp=111", fu_valid); end
    total++; if (fpl(2) !== pl(2)) begin bad++; $display("FAIL rel_pl2 got=%h exp=%h", fpl(2), pl(2)); end
    tick;
    total++; if (issue_count !== 32'd3) begin bad++; $display("FAIL rel_cnt got=%0d exp=3", issue_count); end
    total++; if (fu_valid !== 3'b000) begin bad++; $display("FAIL rel_drain got=%b exp=000", fu_valid); end
  endtask

  task automatic test_age_wrap;
    do_reset;
    set_entry(2, 8'd250, '0); set_entry(5, 8'd3, '0);
    set_entry(9, 8'd254, '0); set_entry(11, 8'd1, '0);
    entry_ready = 16'h0A24; #1;
    total++; if (clear_valid !== 3'b111) begin bad++; $display("FAIL age_cv got=%b exp=111", clear_valid); end
    total++; if (clear_idx !== 12'hB92) begin bad++; $display("FAIL age_idx got=%h exp=b92", clear_idx); end
    tick;
    entry_ready = 16'h0020; #1;
    total++; if (clear_valid !== 3'b001) begin bad++; $display("FAIL age_cv2 got=%b exp=001", clear_valid); end
    total++; if (cidx(0) !== 4'd5) begin bad++; $display("FAIL age_idx2 got=%0d exp=5", cidx(0)); end
    total++; if (fpl(1) !== pl(9)) begin bad++; $display("FAIL age_pl1 got=%h exp=%h", fpl(1), pl(9)); end
    tick;
    entry_ready = '0; #1;
    total++; if (fu_valid !== 3'b001) begin bad++; $display("FAIL age_fuv got=%b exp=001", fu_valid); end
    total++; if (fpl(0) !== pl(5)) begin bad++; $display("FAIL age_pl0 got=%h exp=%h", fpl(0), pl(5)); end
    total++; if (issue_count !== 32'd3) begin bad++; $display("FAIL age_cnt got=%0d exp=3", issue_count); end
  endtask

  task automatic test_stall;
    do_reset;
    entry_ready = 16'h03FF; fu_ready = 3'b101; #1;
    total++; if (clear_idx !== 12'h210) begin bad++; $display("FAIL stl_idx0 got=%h exp=210", clear_idx); end
    for (int k = 0; k < 4; k++) begin
      tick;
      entry_ready = st_rdy[k]; #1;
      total++; if (clear_valid !== st_cv[k]) begin bad++; $display("FAIL stl_cv%0d got=%b exp=%b", k, clear_valid, st_cv[k]); end
      total++; if (cidx(0) !== st_s0[k]) begin bad++; $display("FAIL stl_s0_%0d got=%0d exp=%0d", k, cidx(0), st_s0[k]); end
      if (st_cv[k][2]) begin
        total++; if (cidx(2) !== st_s2[k]) begin bad++; $display("FAIL stl_s2_%0d got=%0d exp=%0d", k, cidx(2), st_s2[k]); end
      end
      total++; if (fpl(1) !== pl(1)) begin bad++; $display("FAIL stl_pl1_%0d got=%h exp=%h", k, fpl(1), pl(1)); end
      total++; if (issue_count !== st_cnt[k]) begin bad++; $display("FAIL stl_cnt%0d got=%0d exp=%0d", k, issue_count, st_cnt[k]); end
    end
    tick;
    entry_ready = '0; #1;
    total++; if (issue_count !== 32'd8) begin bad++; $display("FAIL stl_cnt_end got=%0d exp=8", issue_count); end
    total++; if (fu_valid !== 3'b011) begin bad++; $display("FAIL stl_fuv got=%b exp=011", fu_valid); end
    total++; if (fpl(0) !== pl(9)) begin bad++; $display("FAIL stl_pl0 got=%h exp=%h", fpl(0), pl(9)); end
    total++; if (fpl(1) !== pl(1)) begin bad++; $display("FAIL stl_pl1_end got=%h exp=%h", fpl(1), pl(1)); end
  endtask

  task automatic test_squash;
    do_reset;
    fu_ready = 3'b000;
    set_entry(0, 8'd0, 4'b0010); set_entry(1, 8'd1, 4'b0100);
    entry_ready = 16'h0003; #1;
    total++; if (clear_valid !== 3'b011) begin bad++; $display("FAIL sq_cv0 got=%b exp=011", clear_valid); end
    tick;
    set_entry(3, 8'd2, 4'b0011); set_entry(4, 8'd5, 4'b0000);
    entry_ready = 16'h0018; squash_valid = 1'b1; squash_bmask = 4'b0010; #1;
    total++; if (clear_valid !== 3'b100) begin bad++; $display("FAIL sq_cv got=%b exp=100", clear_valid); end
    total++; if (cidx(2) !== 4'd4) begin bad++; $display("FAIL sq_idx got=%0d exp=4", cidx(2)); end
    total++; if (fbm(0) !== 4'b0010) begin bad++; $display("FAIL sq_bm0 got=%b exp=0010", fbm(0)); end
    tick;
    squash_valid = 1'b0; entry_ready = '0; #1;
    total++; if (fu_valid !== 3'b110) begin bad++; $display("FAIL sq_fuv got=%b exp=110", fu_valid); end
    total++; if (fbm(1) !== 4'b0100) begin bad++; $display("FAIL sq_bm1 got=%b exp=0100", fbm(1)); end
  endtask

  task automatic test_resolve;
    do_reset;
    fu_ready = 3'b000;
    set_entry(0, 8'd0, 4'b0110);
    entry_ready = 16'h0001;
    tick;
    set_entry(1, 8'd1, 4'b1100);
    entry_ready = 16'h0002; resolve_valid = 1'b1; resolve_bmask = 4'b0100; #1;
    total++; if (clear_valid !== 3'b010) begin bad++; $display("FAIL rs_cv got=%b exp=010", clear_valid); end
    tick;
    resolve_valid = 1'b0; entry_ready = '0; #1;
    total++; if (fbm(0) !== 4'b0010) begin bad++; $display("FAIL rs_bm0 got=%b exp=0010", fbm(0)); end
    total++; if (fbm(1) !== 4'b1000) begin bad++; $display("FAIL rs_bm1 got=%b exp=1000", fbm(1)); end
    squash_valid = 1'b1; squash_bmask = 4'b0100;
    tick;
    squash_valid = 1'b0; #1;
    total++; if (fu_valid !== 3'b011) begin bad++; $display("FAIL rs_fuv got=%b exp=011", fu_valid); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_entry(0, 8'd0, '0);
    entry_ready = 16'h0001;
    tick;
    set_entry(1, 8'd1, '0);
    entry_ready = 16'h0002; #1;
    total++; if (clear_valid !== 3'b001) begin bad++; $display("FAIL b2b_cv got=%b exp=001", clear_valid); end
    total++; if (cidx(0) !== 4'd1) begin bad++; $display("FAIL b2b_idx got=%0d exp=1", cidx(0)); end
    total++; if (fpl(0) !== pl(0)) begin bad++; $display("FAIL b2b_pl_a got=%h exp=%h", fpl(0), pl(0)); end
    tick;
    entry_ready = '0; #1;
    total++; if (fu_valid !== 3'b001) begin bad++; $display("FAIL b2b_fuv got=%b exp=001", fu_valid); end
    total++; if (fpl(0) !== pl(1)) begin bad++; $display("FAIL b2b_pl_b got=%h exp=%h", fpl(0), pl(1)); end
    total++; if (issue_count !== 32'd1) begin bad++; $display("FAIL b2b_cnt got=%0d exp=1", issue_count); end
  endtask

  task automatic test_full_and_reset_stall;
    do_reset;
    fu_ready = 3'b000;
    entry_ready = 16'h0007;
    tick;
    entry_ready = 16'h0038; #1;
    total++; if (clear_valid !== 3'b000) begin bad++; $display("FAIL full_cv got=%b exp=000", clear_valid); end
    total++; if (fu_valid !== 3'b111) begin bad++; $display("FAIL full_fuv got=%b exp=111", fu_valid); end
    reset = 1'b0; fu_ready = 3'b111; #1;
    total++; if (clear_valid !== 3'b000) begin bad++; $display("FAIL rstst_cv got=%b exp=000", clear_valid); end
    tick;
    reset = 1'b1; entry_ready = '0; #1;
    total++; if (fu_valid !== 3'b000) begin bad++; $display("FAIL rstst_fuv got=%b exp=000", fu_valid); end
    total++; if (issue_count !== 32'd0) begin bad++; $display("FAIL rstst_cnt got=%0d exp=0", issue_count); end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) entry_payload[i*PW +: PW] = pl(i);
    test_reset;
    test_age_wrap;
    test_stall;
    test_squash;
    test_resolve;
    test_back_to_back;
    test_full_and_reset_stall;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_select_port.md
# issue_select_port

Parametrised, age-ordered issue selector and per-FU issue register for one functional-unit class. Each cycle it picks the oldest ready reservation-station entries, tells the RS bank which entries to clear, and latches them into one issue register slot per FU. It generalises the fixed round-robin issue stage in three ways:
- a valid/ready handshake to each FU, so slots hold while the FU stalls;
- selective squash by branch mask instead of a full flush;
- branch-mask resolve updates to held entries.

One instance sits between each RS bank and its FU group.

## Interface
- NUM_ENTRIES, 16: RS entries in the bank (power of 2, ≥2).
- NUM_FU, 3: FUs / issue slots (1..NUM_ENTRIES).
- PAYLOAD_W, 128: opaque RS entry payload width.
- AGE_W, 8: age tag width; wraps modulo 2^AGE_W.
- BMASK_W, 4: branch-mask width.
- IDX_W, $clog2(NUM_ENTRIES): derived entry index width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- entry_ready  in  NUM_ENTRIES  entry valid with both sources ready.
- entry_age  in  NUM_ENTRIES×AGE_W  dispatch age tag per entry.
- entry_bmask  in  NUM_ENTRIES×BMASK_W  branch mask per entry.
- entry_payload  in  NUM_ENTRIES×PAYLOAD_W  entry contents.
- clear_valid  out  NUM_FU  slot s granted an entry this cycle.
- clear_idx  out  NUM_FU×IDX_W  index granted to slot s.
- fu_valid  out  NUM_FU  slot holds an instruction.
- fu_payload  out  NUM_FU×PAYLOAD_W  held payload.
- fu_bmask  out  NUM_FU×BMASK_W  held branch mask, resolve-updated.
- fu_ready  in  NUM_FU  FU accepts this cycle.
- squash_valid  in  1  mispredict squash.
- squash_bmask  in  BMASK_W  one-hot mispredicted branch bit.
- resolve_valid  in  1  correct-prediction resolve.
- resolve_bmask  in  BMASK_W  one-hot resolved branch bit.
- issue_count  out  32  saturating count of FU handshakes.

## Operation
**Slot state.** Each slot holds: valid, payload, bmask.

**Slot free.** A slot is free when ~valid | (fu_valid & fu_ready).

**Candidate set.**
- An entry is a candidate when entry_ready=1.
- If squash_valid=1, entries with (entry_bmask & squash_bmask)≠0 are excluded.

**Age compare.**
- a is older than b iff ((b−a) mod 2^AGE_W) < 2^(AGE_W−1) and a≠b.
- Ties go to the lower index.

**Selection.**
- Slots are served in index order 0..NUM_FU−1.
- Each free slot takes the oldest remaining candidate, which is then removed from the set.
- Non-free slots take nothing.
- Fewer candidates than free slots leaves the higher-index free slots ungranted.

**Grant.** clear_valid[s]=1 and clear_idx[s]=granted index, combinationally in the same cycle. The RS invalidates that entry at the next edge.

**Slot update at the edge, in priority order:**
1. Squash. squash_valid & ((slot bmask|granted bmask) & squash_bmask)≠0 → valid←0.
2. Grant. valid←1, payload/bmask←entry values.
3. Handshake without grant. valid←0.
4. Otherwise hold.

**Resolve.**
- resolve_valid clears resolve_bmask bits in every held slot bmask.
- It also clears them in bmasks being latched this edge.

**issue_count.** +1 per slot with fu_valid & fu_ready each cycle. Saturates at 2^32−1.

## Timing
**Reset** (reset=0 at an edge):
- All slots invalid; issue_count=0.
- clear_valid forced 0 while reset=0.
- fu_payload/fu_bmask are don't-care while fu_valid=0.
- Reset mid-stall discards the held instruction, no handshake counted.

**Latency.**
- Entry ready in cycle N → fu_valid in cycle N+1.
- Back-to-back issue to the same slot is supported: a handshake and a new grant land in the same cycle.

**Stall.** fu_ready=0 holds payload/bmask stable, with fu_valid=1, indefinitely.

**Squash and handshake in the same cycle.**
- The handshake is counted and the transfer completes.
- The slot becomes invalid.
- The FU squashes by its own bmask.

**Squash and resolve in the same cycle.** Squash is evaluated on the pre-resolve bmask.

**Full.** All slots held and stalled → no clear_valid, RS entries untouched.

**Empty.** No candidates → clear_valid=0.

**Counter saturation.** Once at 2^32−1, issue_count holds.

## Test plan
- Reset: hold reset=0 with entry_ready all-1 → clear_valid=0, fu_valid=0, issue_count=0. Release → next cycle fu_valid=3'b111.
- Age order with wrap: AGE_W=8, ready entries 2/5/9/11 with ages 250/3/254/1, NUM_FU=3 → slot0=idx2, slot1=idx9, slot2=idx11. Entry 5 waits and is granted next cycle to whichever slot is free.
- Stall: fu_ready[1]=0 for 4 cycles → slot1 payload constant, clear_valid[1]=0. Slots 0/2 keep issuing. issue_count rises by 2/cycle with fu_ready[0]=fu_ready[2]=1.
- Selective squash: slot0 bmask 4'b0010, slot1 4'b0100, squash_bmask 4'b0010 → next cycle slot0 invalid, slot1 valid. A ready entry with bmask 4'b0011 is not granted.
- Resolve: slot bmask 4'b0110, resolve_bmask 4'b0100 → fu_bmask 4'b0010 next cycle. A later squash on 4'b0100 leaves the slot valid.
- Simultaneous handshake and grant: slot0 valid, fu_ready[0]=1, new candidate ready → slot0 holds the new payload next cycle with no bubble. issue_count +1.
